rr_mux_arbiter: RTL and testbench
=================================

RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 Parameter W, default 3: data width of each requester channel.
REQ-002 Parameter HOLD, default 4, legal range 1..15: maximum consecutive cycles one requester may own the channel.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req  input  8  request per requester; bit i belongs to requester i.
REQ-006 din  input  8*W  packed data; requester i occupies din[i*W +: W].
REQ-007 grant  output  8  one-hot registered grant, or all-zero.
REQ-008 sel  output  3  registered index of the current owner.
REQ-009 f  output  W  registered data of the current owner.
REQ-010 valid  output  1  high when f carries owner data.

Function
REQ-011 The block SHALL implement a two-state FSM with states IDLE and OWN.
REQ-012 The block SHALL keep a 3-bit round-robin pointer ptr and a HOLD counter cnt of 4 bits.
REQ-013 In IDLE with req == 0, the FSM SHALL stay in IDLE, with grant = 0 and valid = 0.
REQ-014 In IDLE with req != 0, the block SHALL select the first set bit in search order ptr, ptr+1, ..., ptr+7 (mod 8), load sel with it, set grant[sel], clear cnt, and enter OWN on the next edge.
REQ-015 In OWN, every cycle the block SHALL register f <= din[sel] and valid <= 1 (one-cycle latency from din to f).
REQ-016 In OWN, cnt SHALL increment by 1 per cycle.
REQ-017 The block SHALL release the channel when req[sel] is sampled low, or when cnt == HOLD-1, whichever occurs first.
REQ-018 On release, the block SHALL set ptr <= sel+1 mod 8 (wrapping 7 to 0), clear grant and valid, and return to IDLE.
REQ-019 Every ownership SHALL be followed by exactly one IDLE cycle before the next grant.
REQ-020 Requests from other requesters during OWN SHALL have no effect until release.
REQ-021 If req[sel] drops in the same cycle that cnt == HOLD-1, the block SHALL perform a single release with no double pointer advance.
REQ-022 With HOLD = 1, each grant SHALL last exactly one OWN cycle.
REQ-023 Any requester with req held high SHALL be granted within 8*(HOLD+1) cycles (starvation-free).
REQ-024 grant SHALL never have more than one bit set.
REQ-025 In OWN, grant SHALL equal 1 << sel.
REQ-026 f SHALL hold its last value while valid = 0.

Reset
REQ-027 While rst_n = 0, regardless of clk, the block SHALL force state = IDLE, ptr = 0, cnt = 0, sel = 0, grant = 0, f = 0, valid = 0.
REQ-028 Reset asserted during OWN SHALL abort ownership immediately, with no pointer update.
REQ-029 After rst_n deasserts, the first arbitration SHALL search starting from requester 0.

Verification
REQ-030 Reset, then req = 8'h01 held, din[0] = 3'b101, HOLD = 4 -> 1 IDLE cycle, then 4 OWN cycles with sel = 0 and valid = 1, 1 IDLE cycle, then requester 0 is regranted.
REQ-031 req = 8'hFF held -> sel sequence is 0, 1, 2, ..., 7, 0, each owning 4 cycles, separated by single IDLE cycles.
REQ-032 ptr = 7 with req = 8'h81 -> requester 7 is granted, then requester 0 (pointer wrap).
REQ-033 Requester 3 owns the channel and req[3] drops after 2 OWN cycles -> release, ptr = 4, valid low the next cycle.
REQ-034 rst_n pulsed low mid-OWN between clock edges -> all outputs are 0 immediately; after release from reset, arbitration restarts from requester 0.
REQ-035 din changes every cycle during OWN -> f equals the previous cycle's din[sel], and grant is one-hot in every cycle.

Source files
------------

// File: rtl/rr_mux_arbiter.sv
// Round-robin 8:1 arbiter and data mux with a bounded ownership window.
// Ports: req/din in; registered grant (one-hot), sel, f and valid out.
module rr_mux_arbiter #(
  parameter int W    = 3,
  parameter int HOLD = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [7:0]     req,
  input  logic [8*W-1:0] din,
  output logic [7:0]     grant,
  output logic [2:0]     sel,
  output logic [W-1:0]   f,
  output logic           valid
);

  typedef enum logic {
    IDLE,
    OWN
  } state_e;

  // HOLD is limited to 1..15 so the last beat fits the 4-bit counter.
  localparam logic [3:0] CntLast = 4'(HOLD - 1);

  state_e         state_q, state_d;
  logic [2:0]     ptr_q, ptr_d;
  logic [2:0]     sel_q, sel_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [7:0]     grant_q, grant_d;
  logic [W-1:0]   f_q, f_d;
  logic           valid_q, valid_d;

  logic [W-1:0]   din_a [8];
  logic           pick_hit;
  logic [2:0]     pick_idx;
  logic           release_now;

  for (genvar g = 0; g < 8; g++) begin : g_din
    assign din_a[g] = din[g*W +: W];
  end

  // Scan from the far end back toward ptr so the nearest
  // requester in rotated order is the last (winning) write.
  always_comb begin
    pick_hit = 1'b0;
    pick_idx = ptr_q;
    for (int i = 7; i >= 0; i--) begin
      logic [2:0] probe;
      probe = ptr_q + 3'(i);
      if (req[probe]) begin
        pick_hit = 1'b1;
        pick_idx = probe;
      end
    end
  end

  // Owner dropping its request and the last beat may coincide;
  // both collapse into this single release.
  assign release_now = !req[sel_q] || (cnt_q == CntLast);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    f_d     = f_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: begin
        if (pick_hit) begin
          state_d = OWN;
          sel_d   = pick_idx;
          grant_d = 8'd1 << pick_idx;
          cnt_d   = 4'd0;
          f_d     = din_a[pick_idx];
          valid_d = 1'b1;
        end else begin
          grant_d = 8'd0;
          valid_d = 1'b0;
        end
      end
      OWN: begin
        if (release_now) begin
          state_d = IDLE;
          ptr_d   = sel_q + 3'd1;
          grant_d = 8'd0;
          valid_d = 1'b0;
        end else begin
          cnt_d   = cnt_q + 4'd1;
          f_d     = din_a[sel_q];
          valid_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 8'd0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 3'd0;
      sel_q   <= 3'd0;
      cnt_q   <= 4'd0;
      grant_q <= 8'd0;
      f_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      f_q     <= f_d;
      valid_q <= valid_d;
    end
  end

  assign grant = grant_q;
  assign sel   = sel_q;
  assign f     = f_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Scoreboard bench for rr_mux_arbiter (HOLD=4 main DUT, HOLD=1 side DUT).
// Stimulus queues timed expectations; negedge monitors pop and compare.
module tb_rr_mux_arbiter;
  localparam int W = 3;

  typedef struct {
    int cyc;
    int sel;
    int f;
  } exp_t;

  logic           clk;
  logic           rst_n;
  logic [7:0]     req;
  logic [8*W-1:0] din;
  logic [7:0]     grant, grant1;
  logic [2:0]     sel, sel1;
  logic [W-1:0]   f, f1;
  logic           valid, valid1;

  exp_t q[$];
  exp_t q1[$];
  exp_t e, e1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rst_pulses = 0;
  int   seen_pulses = 0;
  logic h1_en = 1'b0;
  logic [W-1:0] last_f = '0;
  int   n, b, x;

  rr_mux_arbiter #(.W(W), .HOLD(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din),
    .grant(grant), .sel(sel), .f(f), .valid(valid)
  );

  rr_mux_arbiter #(.W(W), .HOLD(1)) u_h1 (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din),
    .grant(grant1), .sel(sel1), .f(f1), .valid(valid1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_din(input int i, input int v);
    din[i*W +: W] = W'(v);
  endtask

  function automatic void exp_main(input int c, input int s, input int fv);
    exp_t t;
    t.cyc = c; t.sel = s; t.f = fv;
    q.push_back(t);
  endfunction

  function automatic void exp_h1(input int c, input int s, input int fv);
    exp_t t;
    t.cyc = c; t.sel = s; t.f = fv;
    q1.push_back(t);
  endfunction

  task automatic chk_zero(input string tag);
    checks++;
    if (grant !== 8'd0 || sel !== 3'd0 || f !== '0 || valid !== 1'b0 ||
        grant1 !== 8'd0 || sel1 !== 3'd0 || f1 !== '0 || valid1 !== 1'b0) begin
      errors++;
      $display("FAIL %s grant=%h sel=%0d f=%0d valid=%b h1:%h/%0d/%0d/%b, required all zero",
               tag, grant, sel, f, valid, grant1, sel1, f1, valid1);
    end
  endtask

  // Main DUT monitor.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (!$onehot0(grant)) begin
        errors++;
        $display("FAIL onehot cyc=%0d grant=%b, required at most one bit", cyc, grant);
      end
      if (valid) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL extra_valid cyc=%0d sel=%0d f=%0d, required valid=0", cyc, sel, f);
        end else begin
          e = q.pop_front();
          if (e.cyc != cyc || e.sel != int'(sel) || e.f != int'(f) ||
              grant != (8'd1 << e.sel)) begin
            errors++;
            $display("FAIL own_beat cyc=%0d sel=%0d f=%0d grant=%b, required cyc=%0d sel=%0d f=%0d",
                     cyc, sel, f, grant, e.cyc, e.sel, e.f);
          end
        end
      end else begin
        if (q.size() > 0 && q[0].cyc <= cyc) begin
          e = q.pop_front();
          checks++;
          errors++;
          $display("FAIL missing_valid cyc=%0d valid=0, required sel=%0d f=%0d at cyc=%0d",
                   cyc, e.sel, e.f, e.cyc);
        end
        if (rst_pulses == seen_pulses) begin
          checks++;
          if (f !== last_f) begin
            errors++;
            $display("FAIL f_hold cyc=%0d f=%0d, required %0d", cyc, f, last_f);
          end
        end
      end
    end
    last_f = f;
    seen_pulses = rst_pulses;
  end

  // HOLD=1 DUT monitor, active only in its window.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (!$onehot0(grant1)) begin
        errors++;
        $display("FAIL h1_onehot cyc=%0d grant=%b, required at most one bit", cyc, grant1);
      end
      if (h1_en) begin
        if (valid1) begin
          checks++;
          if (q1.size() == 0) begin
            errors++;
            $display("FAIL h1_extra_valid cyc=%0d sel=%0d, required valid=0", cyc, sel1);
          end else begin
            e1 = q1.pop_front();
            if (e1.cyc != cyc || e1.sel != int'(sel1) || e1.f != int'(f1) ||
                grant1 != (8'd1 << e1.sel)) begin
              errors++;
              $display("FAIL h1_beat cyc=%0d sel=%0d f=%0d grant=%b, required cyc=%0d sel=%0d f=%0d",
                       cyc, sel1, f1, grant1, e1.cyc, e1.sel, e1.f);
            end
          end
        end else if (q1.size() > 0 && q1[0].cyc <= cyc) begin
          e1 = q1.pop_front();
          checks++;
          errors++;
          $display("FAIL h1_missing_valid cyc=%0d, required sel=%0d at cyc=%0d",
                   cyc, e1.sel, e1.cyc);
        end
      end
    end
  end

  initial begin
    req = 8'h00;
    din = '0;
    rst_n = 1'b1;
    #1;
    rst_n = 1'b0;
    repeat (3) tick();
    chk_zero("reset_hold");
    rst_n = 1'b1;
    tick();

    // Single requester: 4 beats, one idle, regrant.
    n = cyc;
    req = 8'h01;
    set_din(0, 5);
    for (int k = 1; k <= 4; k++) exp_main(n + k, 0, 5);
    for (int k = 6; k <= 9; k++) exp_main(n + k, 0, 5);
    repeat (9) tick();
    req = 8'h00;
    tick();

    // Reset while idle, then all requesters: full rotation.
    b = cyc;
    rst_n = 1'b0;
    rst_pulses++;
    #1 chk_zero("reset_idle");
    #1 rst_n = 1'b1;
    req = 8'hFF;
    for (int i = 0; i < 8; i++) set_din(i, i);
    for (int i = 0; i <= 8; i++)
      for (int k = 0; k < 4; k++)
        exp_main(b + 1 + 5*i + k, i % 8, i % 8);
    for (int j = 0; j <= 21; j++) exp_h1(b + 1 + 2*j, j % 8, j % 8);
    h1_en = 1'b1;
    repeat (44) tick();
    req = 8'h00;
    tick();
    h1_en = 1'b0;

    // Drop coincided with last beat: ptr must be 1, not 2.
    req = 8'h03;
    for (int k = 46; k <= 49; k++) exp_main(b + k, 1, 1);
    repeat (4) tick();
    req = 8'h00;
    tick();

    // Drive ptr to 7, then wrap 7 -> 0.
    x = cyc;
    req = 8'h40;
    for (int k = 1; k <= 4; k++) exp_main(x + k, 6, 6);
    repeat (4) tick();
    req = 8'h81;
    for (int k = 6; k <= 9; k++) exp_main(x + k, 7, 7);
    for (int k = 11; k <= 14; k++) exp_main(x + k, 0, 0);
    repeat (10) tick();
    req = 8'h00;
    tick();

    // Requester 3 drops early; next pick starts at 4; din moves each cycle.
    req = 8'h08;
    exp_main(x + 16, 3, 3);
    exp_main(x + 17, 3, 3);
    tick();
    tick();
    req = 8'h00;
    tick();
    req = 8'h18;
    exp_main(x + 19, 4, 2);
    exp_main(x + 20, 4, 7);
    exp_main(x + 21, 4, 0);
    exp_main(x + 22, 4, 5);
    set_din(4, 2); set_din(3, 5);
    tick();
    set_din(4, 7); set_din(3, 0);
    tick();
    set_din(4, 0); set_din(3, 7);
    tick();
    set_din(4, 5); set_din(3, 2);
    tick();
    req = 8'h00;
    tick();

    // Reset mid-ownership between edges; restart from requester 0.
    req = 8'h20;
    exp_main(x + 24, 5, 5);
    exp_main(x + 25, 5, 5);
    tick();
    tick();
    #5;
    rst_n = 1'b0;
    rst_pulses++;
    req = 8'h22;
    #1 chk_zero("reset_own");
    #1 rst_n = 1'b1;
    for (int k = 26; k <= 29; k++) exp_main(x + k, 1, 1);
    repeat (4) tick();
    req = 8'h00;
    repeat (3) tick();

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL main_queue_drain left=%0d, required 0", q.size());
    end
    checks++;
    if (q1.size() != 0) begin
      errors++;
      $display("FAIL h1_queue_drain left=%0d, required 0", q1.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
